// File: rtl/lane_frame_assembler_if.sv
// -----------------------------------------------------------------------------
// lane_frame_assembler_if
//
// Purpose:
//   Bundles the byte-stream input handshake and the frame output handshake of
//   lane_frame_assembler into one interface.
//
// Signals:
//   s_valid     byte on s_data is valid
//   s_ready     assembler can take a byte this cycle
//   s_data      input byte
//   s_last      final byte of a frame (only meaningful with s_valid)
//   m_valid     a completed frame is being presented
//   m_ready     consumer takes the presented frame this cycle
//   m_word      frame bytes 0 (low) and 1 (high)
//   m_lanes     lane i holds frame byte 2+i at bits [8i+7:8i]
//   m_short     frame was cut short by s_last
//   m_frame_id  sequence number of the presented frame
//
// Modports:
//   slave   the assembler side (consumes bytes, produces frames)
//   master  the environment side (produces bytes, consumes frames)
// -----------------------------------------------------------------------------
interface lane_frame_assembler_if #(
    parameter int NUM_UNITS = 2,
    parameter int ID_WIDTH  = 8
);
    logic                   s_valid;
    logic                   s_ready;
    logic [7:0]             s_data;
    logic                   s_last;
    logic                   m_valid;
    logic                   m_ready;
    logic [15:0]            m_word;
    logic [8*NUM_UNITS-1:0] m_lanes;
    logic                   m_short;
    logic [ID_WIDTH-1:0]    m_frame_id;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_word, m_lanes, m_short, m_frame_id
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_word, m_lanes, m_short, m_frame_id
    );
endinterface

// File: rtl/lane_frame_assembler.sv
// -----------------------------------------------------------------------------
// lane_frame_assembler
//
// Purpose:
//   Collects a serial stream of 8-bit bytes into one parallel frame made of a
//   16-bit word followed by NUM_UNITS lane bytes. A frame ends either after
//   FRAME_LEN = 2 + NUM_UNITS bytes or early on s_last. The completed frame is
//   presented with m_valid and held stable until m_ready is seen.
//
// Parameters:
//   NUM_UNITS  number of 8-bit lanes per frame (1..16)
//   ID_WIDTH   width of the wrapping frame sequence counter
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   bus      lane_frame_assembler_if.slave (byte input + frame output)
//   state_o  debug view of the FSM: 0 IDLE, 1 ACTIVE, 2 DONE
// -----------------------------------------------------------------------------
module lane_frame_assembler #(
    parameter int NUM_UNITS = 2,
    parameter int ID_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    lane_frame_assembler_if.slave       bus,
    output logic [1:0]                  state_o
);

    localparam int FRAME_LEN = 2 + NUM_UNITS;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [15:0]            r_word;
    logic [8*NUM_UNITS-1:0] r_lanes;
    logic                   r_short;
    logic                   r_valid;
    logic [ID_WIDTH-1:0]    r_frameId;

    logic                   w_sReady;
    logic                   w_accept;
    logic                   w_lastPos;
    logic                   w_endFrame;

    // Input side is ready whenever no finished frame is being held. It looks
    // only at the state, never at m_ready, so a byte can never be taken in the
    // same cycle as the frame handshake; the handshake costs one bubble cycle.
    assign w_sReady   = !rst && (r_state != ST_DONE);
    assign w_accept   = bus.s_valid && w_sReady;
    assign w_lastPos  = (r_idx == LAST_IDX);
    assign w_endFrame = w_lastPos || bus.s_last;

    // Frame assembly FSM. Every byte is written straight into its final output
    // register position, so the frame fields are registers and m_valid rises on
    // the same edge that captures the last byte. Fields are zeroed at reset and
    // at each handshake so a short frame shows zeros in positions never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_word    <= '0;
            r_lanes   <= '0;
            r_short   <= 1'b0;
            r_valid   <= 1'b0;
            r_frameId <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACTIVE: begin
                    if (w_accept) begin
                        if (r_idx == IDX_W'(0)) begin
                            r_word[7:0] <= bus.s_data;
                        end
                        if (r_idx == IDX_W'(1)) begin
                            r_word[15:8] <= bus.s_data;
                        end
                        for (int i = 0; i < NUM_UNITS; i++) begin
                            if (r_idx == IDX_W'(i + 2)) begin
                                r_lanes[8*i +: 8] <= bus.s_data;
                            end
                        end

                        // A frame closes on its last slot or on s_last; only
                        // the latter, before the last slot, marks it short.
                        if (w_endFrame) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b1;
                            r_short <= !w_lastPos;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= ST_ACTIVE;
                        end
                    end
                end

                ST_DONE: begin
                    // Held frame is released; the sequence number advances
                    // and wraps naturally at the counter width.
                    if (bus.m_ready) begin
                        r_state   <= ST_IDLE;
                        r_idx     <= '0;
                        r_valid   <= 1'b0;
                        r_word    <= '0;
                        r_lanes   <= '0;
                        r_short   <= 1'b0;
                        r_frameId <= r_frameId + ID_WIDTH'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready    = w_sReady;
    assign bus.m_valid    = r_valid;
    assign bus.m_word     = r_word;
    assign bus.m_lanes    = r_lanes;
    assign bus.m_short    = r_short;
    assign bus.m_frame_id = r_frameId;
    assign state_o        = r_state;

endmodule

// File: tb/tb_lane_frame_assembler.sv
// -----------------------------------------------------------------------------
// tb_lane_frame_assembler
//
// Purpose:
//   Self-checking bench for lane_frame_assembler with NUM_UNITS=2 (4-byte
//   frames). A table of per-cycle vectors covers reset, basic frames,
//   backpressure, short frames, s_last corner cases, idle gaps and reset
//   mid-frame; a scoreboarded loop then sends 257 frames across the frame id
//   wrap.
// -----------------------------------------------------------------------------
module tb_lane_frame_assembler;

    localparam int NUM_UNITS = 2;
    localparam int ID_WIDTH  = 8;

    logic       clk;
    logic       rst;
    logic [1:0] state;

    int errorCount;
    int checkCount;

    lane_frame_assembler_if #(.NUM_UNITS(NUM_UNITS), .ID_WIDTH(ID_WIDTH)) bus ();

    lane_frame_assembler #(.NUM_UNITS(NUM_UNITS), .ID_WIDTH(ID_WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .state_o (state)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        rst;
        logic        sValid;
        logic [7:0]  sData;
        logic        sLast;
        logic        mReady;
        logic        expSReady;
        logic        expMValid;
        logic [15:0] expWord;
        logic [15:0] expLanes;
        logic        expShort;
        logic [7:0]  expId;
        logic [1:0]  expState;
    } vec_t;

    vec_t vectors[$];

    // Each vector: inputs driven at the falling edge, expected outputs are what
    // is seen 1 time unit after the following rising edge (inputs still held).
    function automatic void add(logic r, logic sv, logic [7:0] sd, logic sl, logic mr,
                                logic eR, logic eV, logic [15:0] eW, logic [15:0] eL,
                                logic eS, logic [7:0] eI, logic [1:0] eSt);
        vec_t v;
        v.rst = r; v.sValid = sv; v.sData = sd; v.sLast = sl; v.mReady = mr;
        v.expSReady = eR; v.expMValid = eV; v.expWord = eW; v.expLanes = eL;
        v.expShort = eS; v.expId = eI; v.expState = eSt;
        vectors.push_back(v);
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        @(negedge clk);
        rst         = v.rst;
        bus.s_valid = v.sValid;
        bus.s_data  = v.sData;
        bus.s_last  = v.sLast;
        bus.m_ready = v.mReady;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(int idx, vec_t v);
        cmp($sformatf("v%0d s_ready", idx),    32'(bus.s_ready),    32'(v.expSReady));
        cmp($sformatf("v%0d m_valid", idx),    32'(bus.m_valid),    32'(v.expMValid));
        cmp($sformatf("v%0d m_word", idx),     32'(bus.m_word),     32'(v.expWord));
        cmp($sformatf("v%0d m_lanes", idx),    32'(bus.m_lanes),    32'(v.expLanes));
        cmp($sformatf("v%0d m_short", idx),    32'(bus.m_short),    32'(v.expShort));
        cmp($sformatf("v%0d m_frame_id", idx), 32'(bus.m_frame_id), 32'(v.expId));
        cmp($sformatf("v%0d state_o", idx),    32'(state),          32'(v.expState));
    endtask

    // Scoreboard for the wrap test: expected frames queued when sent.
    typedef struct {
        logic [15:0] word;
        logic [15:0] lanes;
        logic [7:0]  id;
    } frame_t;

    frame_t sb[$];

    initial begin
        logic [7:0]  expId;
        logic [7:0]  b [4];
        frame_t      f;
        frame_t      got;
        logic [7:0]  lastIds [3];

        errorCount = 0;
        checkCount = 0;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        //  rst sv data  last mr | sR mV word      lanes     sh id     st
        // Reset state
        add(1, 0, 8'h00, 0, 0,   0, 0, 16'h0000, 16'h0000, 0, 8'd0, 2'd0);
        // Basic frame, m_valid for one cycle; 0x99 offered during DONE is ignored
        add(0, 1, 8'hCD, 0, 1,   1, 0, 16'h00CD, 16'h0000, 0, 8'd0, 2'd1);
        add(0, 1, 8'hAB, 0, 1,   1, 0, 16'hABCD, 16'h0000, 0, 8'd0, 2'd1);
        add(0, 1, 8'h11, 0, 1,   1, 0, 16'hABCD, 16'h0011, 0, 8'd0, 2'd1);
        add(0, 1, 8'h22, 0, 1,   0, 1, 16'hABCD, 16'h2211, 0, 8'd0, 2'd2);
        add(0, 1, 8'h99, 0, 1,   1, 0, 16'h0000, 16'h0000, 0, 8'd1, 2'd0);
        // Repeat frame shows id 1
        add(0, 1, 8'hCD, 0, 1,   1, 0, 16'h00CD, 16'h0000, 0, 8'd1, 2'd1);
        add(0, 1, 8'hAB, 0, 1,   1, 0, 16'hABCD, 16'h0000, 0, 8'd1, 2'd1);
        add(0, 1, 8'h11, 0, 1,   1, 0, 16'hABCD, 16'h0011, 0, 8'd1, 2'd1);
        add(0, 1, 8'h22, 0, 1,   0, 1, 16'hABCD, 16'h2211, 0, 8'd1, 2'd2);
        add(0, 0, 8'h00, 0, 1,   1, 0, 16'h0000, 16'h0000, 0, 8'd2, 2'd0);
        // Backpressure: hold for 5 cycles with 0x55 waiting
        add(0, 1, 8'h01, 0, 0,   1, 0, 16'h0001, 16'h0000, 0, 8'd2, 2'd1);
        add(0, 1, 8'h02, 0, 0,   1, 0, 16'h0201, 16'h0000, 0, 8'd2, 2'd1);
        add(0, 1, 8'h03, 0, 0,   1, 0, 16'h0201, 16'h0003, 0, 8'd2, 2'd1);
        add(0, 1, 8'h04, 0, 0,   0, 1, 16'h0201, 16'h0403, 0, 8'd2, 2'd2);
        for (int i = 0; i < 5; i++)
            add(0, 1, 8'h55, 0, 0, 0, 1, 16'h0201, 16'h0403, 0, 8'd2, 2'd2);
        add(0, 1, 8'h55, 0, 1,   1, 0, 16'h0000, 16'h0000, 0, 8'd3, 2'd0);
        add(0, 1, 8'h55, 0, 1,   1, 0, 16'h0055, 16'h0000, 0, 8'd3, 2'd1);
        add(0, 1, 8'h66, 1, 1,   0, 1, 16'h6655, 16'h0000, 1, 8'd3, 2'd2);
        add(0, 0, 8'h00, 0, 1,   1, 0, 16'h0000, 16'h0000, 0, 8'd4, 2'd0);
        // Short frame 0x34, 0x12+last
        add(0, 1, 8'h34, 0, 1,   1, 0, 16'h0034, 16'h0000, 0, 8'd4, 2'd1);
        add(0, 1, 8'h12, 1, 1,   0, 1, 16'h1234, 16'h0000, 1, 8'd4, 2'd2);
        add(0, 0, 8'h00, 0, 1,   1, 0, 16'h0000, 16'h0000, 0, 8'd5, 2'd0);
        // Full frame with s_last on 4th byte: not short, no residue
        add(0, 1, 8'hA1, 0, 1,   1, 0, 16'h00A1, 16'h0000, 0, 8'd5, 2'd1);
        add(0, 1, 8'hB2, 0, 1,   1, 0, 16'hB2A1, 16'h0000, 0, 8'd5, 2'd1);
        add(0, 1, 8'hC3, 0, 1,   1, 0, 16'hB2A1, 16'h00C3, 0, 8'd5, 2'd1);
        add(0, 1, 8'hD4, 1, 1,   0, 1, 16'hB2A1, 16'hD4C3, 0, 8'd5, 2'd2);
        add(0, 0, 8'h00, 0, 1,   1, 0, 16'h0000, 16'h0000, 0, 8'd6, 2'd0);
        // Single byte with s_last in IDLE
        add(0, 1, 8'h7F, 1, 1,   0, 1, 16'h007F, 16'h0000, 1, 8'd6, 2'd2);
        add(0, 0, 8'h00, 0, 1,   1, 0, 16'h0000, 16'h0000, 0, 8'd7, 2'd0);
        // s_last without s_valid is ignored
        add(0, 0, 8'hEE, 1, 1,   1, 0, 16'h0000, 16'h0000, 0, 8'd7, 2'd0);
        // Two bytes, idle gaps, then reset mid-frame
        add(0, 1, 8'h01, 0, 1,   1, 0, 16'h0001, 16'h0000, 0, 8'd7, 2'd1);
        add(0, 1, 8'h02, 0, 1,   1, 0, 16'h0201, 16'h0000, 0, 8'd7, 2'd1);
        for (int i = 0; i < 3; i++)
            add(0, 0, 8'hAA, 0, 1, 1, 0, 16'h0201, 16'h0000, 0, 8'd7, 2'd1);
        add(1, 1, 8'h03, 0, 1,   0, 0, 16'h0000, 16'h0000, 0, 8'd0, 2'd0);
        add(0, 0, 8'h00, 0, 1,   1, 0, 16'h0000, 16'h0000, 0, 8'd0, 2'd0);
        add(0, 1, 8'h10, 0, 1,   1, 0, 16'h0010, 16'h0000, 0, 8'd0, 2'd1);
        add(0, 1, 8'h20, 0, 1,   1, 0, 16'h2010, 16'h0000, 0, 8'd0, 2'd1);
        add(0, 1, 8'h30, 0, 1,   1, 0, 16'h2010, 16'h0030, 0, 8'd0, 2'd1);
        add(0, 1, 8'h40, 0, 1,   0, 1, 16'h2010, 16'h4030, 0, 8'd0, 2'd2);
        add(0, 0, 8'h00, 0, 1,   1, 0, 16'h0000, 16'h0000, 0, 8'd1, 2'd0);

        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i]);
            checkOutput(i, vectors[i]);
        end

        // Sequence wrap: reset, then 257 frames with pseudo-random bytes,
        // checked against a scoreboard and an independent id counter.
        @(negedge clk);
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expId = 8'd0;
        for (int fr = 0; fr < 257; fr++) begin
            for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 255));
            f.word  = {b[1], b[0]};
            f.lanes = {b[3], b[2]};
            f.id    = expId;
            sb.push_back(f);
            expId = expId + 8'd1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                bus.s_valid = 1'b1;
                bus.s_data  = b[k];
                bus.m_ready = 1'b0;
                if (bus.s_ready !== 1'b1) begin
                    errorCount++;
                    $display("[TB] FAIL wrap s_ready frame %0d byte %0d: got %b expected 1", fr, k, bus.s_ready);
                end
                checkCount++;
            end
            @(negedge clk);
            bus.s_valid = 1'b0;
            bus.m_ready = 1'b1;
            cmp($sformatf("wrap m_valid f%0d", fr), 32'(bus.m_valid), 32'd1);
            if (sb.size() == 0) begin
                cmp($sformatf("wrap sb empty f%0d", fr), 32'(sb.size()), 32'd1);
            end else begin
                got = sb.pop_front();
                cmp($sformatf("wrap m_word f%0d", fr),     32'(bus.m_word),     32'(got.word));
                cmp($sformatf("wrap m_lanes f%0d", fr),    32'(bus.m_lanes),    32'(got.lanes));
                cmp($sformatf("wrap m_short f%0d", fr),    32'(bus.m_short),    32'd0);
                cmp($sformatf("wrap m_frame_id f%0d", fr), 32'(bus.m_frame_id), 32'(got.id));
            end
            if (fr >= 254) lastIds[fr-254] = bus.m_frame_id;
            @(posedge clk);
        end
        cmp("wrap scoreboard leftover", 32'(sb.size()), 32'd0);
        cmp("wrap id 254", 32'(lastIds[0]), 32'd254);
        cmp("wrap id 255", 32'(lastIds[1]), 32'd255);
        cmp("wrap id 0",   32'(lastIds[2]), 32'd0);

        @(negedge clk);
        bus.m_ready = 1'b0;
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/lane_frame_assembler.md
Name: lane_frame_assembler

Overview:
- Upstream feeder for the multi-lane datapath.
- Collects a serial 8-bit byte stream, accepted under a valid/ready handshake, into one parallel frame.
- Each frame is one 16-bit word (the `data_in_b`-style input) plus NUM_UNITS 8-bit lane bytes (the `data_in_c[]` input).
- Presents each completed frame with valid/ready and holds it until the consumer accepts it.

Parameters:
- NUM_UNITS, 2, number of 8-bit lanes per frame; legal range 1..16.
- ID_WIDTH, 8, width of the frame sequence counter.
- Derived localparam FRAME_LEN = 2 + NUM_UNITS, the number of bytes per full frame.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input byte valid.
- s_ready  out  1  block can accept a byte.
- s_data  in  8  input byte.
- s_last  in  1  marks the final byte of a frame; qualified by s_valid.
- m_valid  out  1  completed frame available.
- m_ready  in  1  consumer accepts the frame.
- m_word  out  16  frame bytes 0 (low) and 1 (high).
- m_lanes  out  8*NUM_UNITS  lane i = frame byte 2+i, placed at bits [8i+7:8i].
- m_short  out  1  frame was terminated early by s_last.
- m_frame_id  out  ID_WIDTH  sequence number of the presented frame.
- state_o  out  2  FSM state for debug: 0 IDLE, 1 ACTIVE, 2 DONE.

Behaviour:
- Reset, sampled at a clock edge with rst=1, returns everything to the idle condition:
  - state=IDLE, byte index idx=0.
  - m_word, m_lanes, m_short, m_valid, m_frame_id all 0.
  - s_ready=0 while rst=1.
- Reset mid-frame or mid-hold discards all partial or held data. There is no stale data afterwards and m_frame_id restarts at 0.
- s_ready = !rst && (state != DONE), combinational from state only. It never depends on m_ready, so a byte is never accepted in the same cycle as a frame handshake.
- A byte is accepted on a cycle with s_valid && s_ready. On acceptance:
  - Write s_data into frame byte position idx of the output registers.
  - If idx == FRAME_LEN-1 or s_last=1: go to DONE and set m_short = (idx != FRAME_LEN-1).
  - Otherwise: idx <= idx+1 and state=ACTIVE.
- States:
  - IDLE: no bytes held (idx=0).
  - ACTIVE: 1..FRAME_LEN-1 bytes held. Gaps in s_valid are allowed in ACTIVE; the state and the held bytes are kept indefinitely.
  - DONE: frame held, m_valid=1.
- Latency:
  - m_valid rises on the clock edge that accepts the final byte, so it is visible the next cycle.
  - The outputs are registers, not combinational paths from s_data.
- Hold rule: while in DONE with m_ready=0, m_valid, m_word, m_lanes, m_short and m_frame_id hold stable, and s_ready=0.
- Handshake (DONE with m_ready=1), at that edge:
  - state <= IDLE, idx <= 0, m_valid <= 0.
  - m_word, m_lanes and m_short are cleared to 0.
  - m_frame_id <= m_frame_id+1, wrapping from 2^ID_WIDTH-1 to 0.
- Short frames: positions not written stay 0, because the fields are cleared at the handshake and at reset.
- s_last on the final (FRAME_LEN-th) byte is a normal frame with m_short=0.
- s_last on the first byte accepted in IDLE produces a one-byte short frame.
- s_last without s_valid is ignored.
- Throughput: at most one frame per FRAME_LEN+1 cycles, because of the one-cycle DONE/handshake bubble.
- m_frame_id of the first frame after reset is 0.
- Bytes that are not accepted (s_ready=0) do not alter any state.

Test Plan (NUM_UNITS=2, FRAME_LEN=4):
1. Basic frame:
   - Stimulus: after reset, send bytes 0xCD, 0xAB, 0x11, 0x22 back-to-back with m_ready=1.
   - Required: m_valid high for exactly 1 cycle, one cycle after the 4th byte is accepted; m_word=0xABCD, m_lanes=0x2211, m_short=0, m_frame_id=0.
   - Repeat the frame: the second frame shows m_frame_id=1.
2. Backpressure:
   - Stimulus: complete a frame with m_ready=0 for 5 cycles while s_valid=1 with 0x55.
   - Required: m_valid and all data fields stable, and s_ready=0 throughout.
   - Then m_ready=1: handshake occurs; the next cycle s_ready=1 and 0x55 lands in byte 0 of the new frame.
3. Short frame:
   - Stimulus: 0x34, then 0x12 with s_last=1.
   - Required: m_word=0x1234, m_lanes=0x0000, m_short=1.
   - Follow-up: a following full frame shows no residue from this one.
4. Edge cases for s_last:
   - s_last on the 4th byte → m_short=0.
   - Single byte 0x7F with s_last in IDLE → m_word=0x007F, m_short=1.
5. Idle gaps and reset mid-frame:
   - Stimulus: 2 bytes, then 3 idle cycles.
   - Required: state_o=1 (ACTIVE) holds through the idle cycles.
   - Stimulus: assert rst for 1 cycle.
   - Required: state_o=0, s_ready=0 during reset, m_frame_id=0; the next frame completes cleanly.
6. Sequence wrap: send 257 frames. Required: m_frame_id sequence is ...254, 255, 0; no dropped or duplicated frames, checked by scoreboard.
